// File: rtl/jp_emu_pkg.sv
// jp_emu_pkg: shared joypad button indices and shifter constants
package jp_emu_pkg;
    localparam int JP_NUM_BTNS  = 8;
    localparam int JP_BTN_A     = 0;
    localparam int JP_BTN_B     = 1;
    localparam int JP_BTN_SEL   = 2;
    localparam int JP_BTN_START = 3;
    localparam int JP_BTN_UP    = 4;
    localparam int JP_BTN_DOWN  = 5;
    localparam int JP_BTN_LEFT  = 6;
    localparam int JP_BTN_RIGHT = 7;
    localparam int JP_CNT_MAX   = 8;
    typedef logic [JP_NUM_BTNS-1:0] jp_btns_t;
endpackage

// File: rtl/jp_debounce.sv
// jp_debounce: accepts a synchronised raw bit once it has differed from the accepted state for DEBOUNCE_CYCLES cycles
module jp_debounce
    import jp_emu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic raw,
    output logic state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // count while raw disagrees with the accepted state; any agreement restarts the count
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (raw == state) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= raw;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/jp_emu.sv
// jp_emu: emulated NES controller (4021-style responder) with debounce and A/B turbo
module jp_emu
    import jp_emu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TURBO_HALF      = 1666666,
    parameter bit DATA_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_in,
    input  logic       nrst_in,
    input  logic [7:0] btn_in,
    input  logic [1:0] turbo_en_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    output logic       jp_data_out,
    output logic [7:0] btn_state_out
);
    localparam int TW = $clog2(TURBO_HALF + 1);
    localparam logic [TW-1:0] TLAST = TW'(TURBO_HALF - 1);

    jp_btns_t      btn_m, btn_s, eff, sr;
    logic          lat_m, lat_s, lat_d, ck_m, ck_s, ck_d;
    logic [TW-1:0] tcnt;
    logic          phase, dq;
    logic [3:0]    cnt;

    // two-flop synchronisers, plus a third delayed flop on latch/clk for edge detection
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            btn_m <= '0;
            btn_s <= '0;
            {lat_m, lat_s, lat_d} <= '0;
            {ck_m, ck_s, ck_d}    <= '0;
        end else begin
            btn_m <= btn_in;
            btn_s <= btn_m;
            {lat_m, lat_s, lat_d} <= {jp_latch_in, lat_m, lat_s};
            {ck_m, ck_s, ck_d}    <= {jp_clk_in, ck_m, ck_s};
        end
    end

    genvar i;
    generate
        for (i = 0; i < JP_NUM_BTNS; i++) begin : g_db
            jp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk_in (clk_in),
                .nrst_in(nrst_in),
                .raw    (btn_s[i]),
                .state  (btn_state_out[i])
            );
        end
    endgenerate

    // free-running turbo half-period counter; phase flips on every wrap
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            tcnt  <= '0;
            phase <= 1'b0;
        end else if (tcnt == TLAST) begin
            tcnt  <= '0;
            phase <= ~phase;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // turbo masks A/B to the pressed state only while phase is high
    always_comb begin
        eff           = btn_state_out;
        eff[JP_BTN_A] = btn_state_out[JP_BTN_A] & (~turbo_en_in[0] | phase);
        eff[JP_BTN_B] = btn_state_out[JP_BTN_B] & (~turbo_en_in[1] | phase);
    end

    // transparent load while latched; shift in ones on a clk rise, ignoring the cycle latch drops
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            sr  <= '0;
            cnt <= '0;
            dq  <= 1'b0;
        end else begin
            dq <= sr[0];
            if (lat_s) begin
                sr  <= eff;
                cnt <= '0;
            end else if (ck_s && !ck_d && !lat_d) begin
                sr  <= {1'b1, sr[7:1]};
                cnt <= (cnt == 4'(JP_CNT_MAX)) ? cnt : cnt + 1'b1;
            end
        end
    end

    assign jp_data_out = dq ^ DATA_ACTIVE_LOW;
endmodule

// File: tb/tb_jp_emu.sv
// tb_jp_emu: randomized scoreboard bench for jp_emu, active-low and active-high wire variants side by side
module tb_jp_emu;
    localparam int DBC = 4;
    localparam int TH  = 8;

    typedef struct {
        string      nm;
        bit         kind;
        logic [7:0] v;
    } exp_t;

    logic       clk = 1'b0, nrst = 1'b0, latch = 1'b0, jclk = 1'b0;
    logic [7:0] btn = '0;
    logic [1:0] ten = '0;
    logic       wa, wb;
    logic [7:0] sa, sb;
    int         checks = 0, failures = 0, ncyc = 0;
    bit         chk = 1'b0;
    exp_t       q[$];

    jp_emu #(.DEBOUNCE_CYCLES(DBC), .TURBO_HALF(TH), .DATA_ACTIVE_LOW(1'b1)) u_dut_al (
        .clk_in(clk), .nrst_in(nrst), .btn_in(btn), .turbo_en_in(ten),
        .jp_latch_in(latch), .jp_clk_in(jclk), .jp_data_out(wa), .btn_state_out(sa)
    );
    jp_emu #(.DEBOUNCE_CYCLES(DBC), .TURBO_HALF(TH), .DATA_ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk_in(clk), .nrst_in(nrst), .btn_in(btn), .turbo_en_in(ten),
        .jp_latch_in(latch), .jp_clk_in(jclk), .jp_data_out(wb), .btn_state_out(sb)
    );

    always #5 clk = ~clk;

    // cycles elapsed since reset release; the turbo phase model is derived from it
    always @(posedge clk or negedge nrst) begin
        if (!nrst) ncyc <= 0;
        else ncyc <= ncyc + 1;
    end

    // monitor: pops one expectation whenever the stimulus flags a sample point
    always @(negedge clk) begin : mon
        exp_t e;
        if (chk) begin
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: sample requested with no expectation queued");
            end else begin
                e = q.pop_front();
                checks++;
                if (!e.kind) begin
                    if (wa !== ~e.v[0] || wb !== e.v[0]) begin
                        failures++;
                        $display("FAIL %s: wire_al=%b wire_ah=%b required %b/%b", e.nm, wa, wb, ~e.v[0], e.v[0]);
                    end
                end else if (sa !== e.v || sb !== e.v) begin
                    failures++;
                    $display("FAIL %s: btn_state=%h/%h required %h", e.nm, sa, sb, e.v);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_wire(input logic b, input string nm);
        q.push_back('{nm, 1'b0, {7'b0, b}});
        chk = 1'b1;
        tick(1);
        chk = 1'b0;
    endtask

    task automatic exp_state(input logic [7:0] v, input string nm);
        q.push_back('{nm, 1'b1, v});
        chk = 1'b1;
        tick(1);
        chk = 1'b0;
    endtask

    // reference: read k of a transfer is snapshot bit k, then logical 1 forever
    task automatic pulses(input logic [7:0] snap, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            jclk = 1'b1;
            tick(5);
            exp_wire(k < 8 ? snap[k] : 1'b1, $sformatf("read%0d", k));
            jclk = 1'b0;
            tick(6);
        end
    endtask

    task automatic read_seq(input logic [7:0] snap, input int np);
        latch = 1'b1;
        tick(6);
        exp_wire(snap[0], "latch_hi_A");
        latch = 1'b0;
        tick(5);
        exp_wire(snap[0], "read0");
        pulses(snap, 1, np);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int tgt;
        // reset with buttons held, then release
        btn = 8'hFF;
        tick(3);
        exp_wire(1'b0, "reset_wire");
        exp_state(8'h00, "reset_state");
        nrst = 1'b1;
        exp_state(8'h00, "release_state");
        tick(10);
        exp_wire(1'b0, "prelatch_wire");
        exp_state(8'hFF, "held_state");
        // A + Start, read past the end into the fill
        btn = 8'h09;
        tick(10);
        read_seq(8'h09, 12);
        // random button patterns
        repeat (6) begin
            b = 8'($urandom);
            btn = b;
            tick(10);
            exp_state(b, "rand_state");
            read_seq(b, 9);
        end
        // debounce: 3-cycle glitch rejected, sustained press accepted 4 cycles after sync
        btn = 8'h00;
        tick(10);
        btn = 8'h10;
        for (int i = 0; i < 3; i++) exp_state(8'h00, "glitch_hi");
        btn = 8'h00;
        repeat (6) exp_state(8'h00, "glitch_after");
        btn = 8'h10;
        for (int i = 0; i < 9; i++) exp_state(i >= 6 ? 8'h10 : 8'h00, $sformatf("db_edge%0d", i));
        // turbo on A: sample mid-phase, phase from elapsed cycles
        btn = 8'h01;
        ten = 2'b01;
        tick(10);
        repeat (8) begin
            tgt = $urandom_range(0, 1) ? 12 : 4;
            latch = 1'b1;
            tick(5);
            for (int w = 0; w < 16 && ((ncyc - 2) % 16) != tgt; w++) tick(1);
            exp_wire(tgt == 12, "turbo_A");
            latch = 1'b0;
            tick(6);
        end
        ten = 2'b00;
        repeat (3) begin
            latch = 1'b1;
            tick(6);
            exp_wire(1'b1, "noturbo_A");
            latch = 1'b0;
            tick(6);
        end
        // clk rise while latched: load wins
        b = 8'($urandom);
        btn = b;
        tick(10);
        latch = 1'b1;
        tick(6);
        jclk = 1'b1;
        tick(6);
        exp_wire(b[0], "clk_in_latch");
        jclk = 1'b0;
        tick(6);
        latch = 1'b0;
        tick(6);
        exp_wire(b[0], "after_latch");
        pulses(b, 1, 8);
        // latch fall and clk rise together: no shift
        latch = 1'b1;
        tick(6);
        latch = 1'b0;
        jclk = 1'b1;
        tick(5);
        exp_wire(b[0], "merged_A");
        jclk = 1'b0;
        tick(6);
        pulses(b, 1, 8);
        // button change mid-transfer does not disturb the snapshot
        read_seq(b, 3);
        btn = ~b;
        tick(10);
        pulses(b, 4, 9);
        // reset after 3 shifts, then a clean transfer
        b = 8'($urandom) | 8'h08;
        btn = b;
        tick(10);
        read_seq(b, 3);
        nrst = 1'b0;
        exp_wire(1'b0, "midreset_wire");
        exp_state(8'h00, "midreset_state");
        nrst = 1'b1;
        tick(10);
        read_seq(b, 9);
        tick(2);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d expectations never sampled, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
